// File: rtl/common_pkg.sv
// ---------------------------------------------------------------------------
// common: base types shared across the pipeline.
//   u32 / u64    : plain unsigned word types
//   ibus_req_t   : instruction-bus request  {valid, addr}
//   ibus_resp_t  : instruction-bus response {addr_ok, data_ok, data}
//   PCINIT_DEFAULT : default reset PC for the fetch stage
// ---------------------------------------------------------------------------
package common;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;

    localparam u64 PCINIT_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/pipes_pkg.sv
// ---------------------------------------------------------------------------
// pipes: inter-stage payload types and per-stage state encodings.
//   fetch_data_t  : fetch -> decode slot {valid, pc, raw_instr}
//   fetch_state_t : fetch bus-sequencing states
// ---------------------------------------------------------------------------
package pipes;

    typedef struct packed {
        logic       valid;
        common::u64 pc;
        common::u32 raw_instr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch: RV64 instruction-fetch stage.
// Holds the PC, issues single-outstanding requests on the instruction bus and
// registers each returned word with its PC into a one-entry slot for decode.
// Redirects flush the slot and mark an in-flight request stale so its data is
// dropped when it eventually returns.
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   reset          in   synchronous active-high reset
//   ireq           out  bus request {valid, addr}, registered
//   iresp          in   bus response {addr_ok, data_ok, data}
//   redirect_valid in   later stage requests a PC change this cycle
//   redirect_pc    in   new PC (4-byte aligned)
//   d_ready        in   decode accepts the slot this cycle
//   dataF          out  output slot {valid, pc, raw_instr}, registered
// ---------------------------------------------------------------------------
module fetch
    import common::*;
    import pipes::*;
#(
    parameter u64 PCINIT = PCINIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  u64          redirect_pc,
    input  logic        d_ready,
    output fetch_data_t dataF
);

    fetch_state_t r_state;
    u64           r_pc;
    u64           r_req_pc;
    logic         r_stale;
    logic         r_ireq_valid;
    u64           r_ireq_addr;
    fetch_data_t  r_slot;

    logic w_consume;
    logic w_complete;
    logic w_accept;
    logic w_start;

    assign w_consume  = r_slot.valid && d_ready;
    // Data only counts in ADDR once the address phase is also accepted.
    assign w_complete = ((r_state == ADDR) && iresp.addr_ok && iresp.data_ok) ||
                        ((r_state == DATA) && iresp.data_ok);
    assign w_accept   = w_complete && !r_stale && !redirect_valid;
    assign w_start    = (r_state == IDLE) && !redirect_valid &&
                        (!r_slot.valid || d_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= PCINIT;
            r_req_pc     <= '0;
            r_stale      <= 1'b0;
            r_ireq_valid <= 1'b0;
            r_ireq_addr  <= '0;
            r_slot       <= '0;
        end else begin
            // Output slot: flush beats refill, refill beats consume.
            if (redirect_valid) begin
                r_slot.valid <= 1'b0;
            end else if (w_accept) begin
                r_slot.valid     <= 1'b1;
                r_slot.pc        <= r_req_pc;
                r_slot.raw_instr <= iresp.data;
            end else if (w_consume) begin
                r_slot.valid <= 1'b0;
            end

            // PC-next mux.
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_req_pc + 64'd4;
            end

            // A redirect while a request is outstanding poisons its data.
            if (redirect_valid && (r_state != IDLE) && !w_complete) begin
                r_stale <= 1'b1;
            end else if (w_complete) begin
                r_stale <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state      <= ADDR;
                        r_req_pc     <= r_pc;
                        r_ireq_valid <= 1'b1;
                        r_ireq_addr  <= r_pc;
                    end
                end
                ADDR: begin
                    if (iresp.addr_ok) begin
                        r_ireq_valid <= 1'b0;
                        r_state      <= iresp.data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (iresp.data_ok) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_ireq_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ireq.valid = r_ireq_valid;
    assign ireq.addr  = r_ireq_addr;
    assign dataF      = r_slot;

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch: directed self-checking bench for the fetch stage.
// A small bus responder answers requests with configurable address/data
// latency; each scenario task drives redirect/d_ready and checks outputs
// 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch;
    import common::*;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    u64          redirect_pc;
    logic        d_ready;
    fetch_data_t dataF;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder configuration.
    int   addr_lat = 0;
    int   data_lat = 0;
    logic ovr_en   = 1'b0;
    u32   ovr_word = 32'h0;

    u64 pc_exp;

    fetch #(.PCINIT(64'h0000_0000_8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_ready        (d_ready),
        .dataF          (dataF)
    );

    always #5 clk = ~clk;

    function automatic u32 word_of(input u64 a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Bus responder: decides iresp for the coming edge, 1 unit after each edge.
    initial begin : responder
        int   acnt;
        int   dwait;
        logic pending;
        u64   paddr;
        acnt    = 0;
        dwait   = 0;
        pending = 1'b0;
        paddr   = '0;
        iresp   = '0;
        forever begin
            @(posedge clk);
            #1;
            iresp = '0;
            if (reset) begin
                acnt    = 0;
                pending = 1'b0;
            end else if (pending) begin
                dwait = dwait - 1;
                if (dwait <= 0) begin
                    pending       = 1'b0;
                    iresp.data_ok = 1'b1;
                    iresp.data    = ovr_en ? ovr_word : word_of(paddr);
                end
            end else if (ireq.valid) begin
                if (acnt < addr_lat) begin
                    acnt = acnt + 1;
                end else begin
                    acnt          = 0;
                    iresp.addr_ok = 1'b1;
                    if (data_lat == 0) begin
                        iresp.data_ok = 1'b1;
                        iresp.data    = ovr_en ? ovr_word : word_of(ireq.addr);
                    end else begin
                        pending = 1'b1;
                        dwait   = data_lat;
                        paddr   = ireq.addr;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        n_tests++;
        if (ireq !== '0) begin
            n_fail++;
            $display("FAIL reset_ireq: got valid=%b addr=%h, want 0/0", ireq.valid, ireq.addr);
        end
        n_tests++;
        if (dataF !== '0) begin
            n_fail++;
            $display("FAIL reset_dataF: got valid=%b pc=%h instr=%h, want all 0",
                     dataF.valid, dataF.pc, dataF.raw_instr);
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        pc_exp = 64'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_tests++;
            if ({ireq.valid, ireq.addr, dataF.valid} !== {1'b1, pc_exp, 1'b0}) begin
                n_fail++;
                $display("FAIL stream_req%0d: got v=%b addr=%h dv=%b, want 1 %h 0",
                         k, ireq.valid, ireq.addr, dataF.valid, pc_exp);
            end
            cyc();
            n_tests++;
            if ({ireq.valid, dataF.valid, dataF.pc, dataF.raw_instr} !==
                {1'b0, 1'b1, pc_exp, word_of(pc_exp)}) begin
                n_fail++;
                $display("FAIL stream_data%0d: got iv=%b dv=%b pc=%h instr=%h, want 0 1 %h %h",
                         k, ireq.valid, dataF.valid, dataF.pc, dataF.raw_instr,
                         pc_exp, word_of(pc_exp));
            end
            pc_exp = pc_exp + 64'd4;
        end
    endtask

    task automatic test_data_delay();
        data_lat = 3;
        for (int r = 0; r < 2; r++) begin
            cyc();
            n_tests++;
            if ({ireq.valid, ireq.addr} !== {1'b1, pc_exp}) begin
                n_fail++;
                $display("FAIL delay_req%0d: got v=%b addr=%h, want 1 %h",
                         r, ireq.valid, ireq.addr, pc_exp);
            end
            for (int w = 0; w < 3; w++) begin
                cyc();
                n_tests++;
                if ({ireq.valid, dataF.valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL delay_wait%0d_%0d: got iv=%b dv=%b, want 0 0",
                             r, w, ireq.valid, dataF.valid);
                end
            end
            cyc();
            n_tests++;
            if ({dataF.valid, dataF.pc, dataF.raw_instr} !== {1'b1, pc_exp, word_of(pc_exp)}) begin
                n_fail++;
                $display("FAIL delay_data%0d: got dv=%b pc=%h instr=%h, want 1 %h %h",
                         r, dataF.valid, dataF.pc, dataF.raw_instr, pc_exp, word_of(pc_exp));
            end
            pc_exp = pc_exp + 64'd4;
        end
    endtask

    task automatic test_backpressure();
        u64 held;
        held    = pc_exp - 64'd4;
        d_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            cyc();
            n_tests++;
            if ({ireq.valid, dataF.valid, dataF.pc, dataF.raw_instr} !==
                {1'b0, 1'b1, held, word_of(held)}) begin
                n_fail++;
                $display("FAIL stall%0d: got iv=%b dv=%b pc=%h instr=%h, want 0 1 %h %h",
                         s, ireq.valid, dataF.valid, dataF.pc, dataF.raw_instr,
                         held, word_of(held));
            end
        end
        d_ready  = 1'b1;
        data_lat = 0;
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr, dataF.valid} !== {1'b1, pc_exp, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_resume: got v=%b addr=%h dv=%b, want 1 %h 0",
                     ireq.valid, ireq.addr, dataF.valid, pc_exp);
        end
        cyc();
        n_tests++;
        if ({dataF.valid, dataF.pc} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL stall_data: got dv=%b pc=%h, want 1 %h", dataF.valid, dataF.pc, pc_exp);
        end
        pc_exp = pc_exp + 64'd4;
    endtask

    task automatic test_redirect_data();
        data_lat = 3;
        ovr_en   = 1'b1;
        ovr_word = 32'hDEAD_BEEF;
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL rd_req: got v=%b addr=%h, want 1 %h", ireq.valid, ireq.addr, pc_exp);
        end
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        for (int w = 0; w < 3; w++) begin
            cyc();
            redirect_valid = 1'b0;
            n_tests++;
            if ({ireq.valid, dataF.valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL rd_drop%0d: got iv=%b dv=%b instr=%h, want 0 0",
                         w, ireq.valid, dataF.valid, dataF.raw_instr);
            end
        end
        data_lat = 0;
        ovr_en   = 1'b0;
        pc_exp   = 64'h8000_1000;
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL rd_newreq: got v=%b addr=%h, want 1 %h", ireq.valid, ireq.addr, pc_exp);
        end
        cyc();
        n_tests++;
        if ({dataF.valid, dataF.pc, dataF.raw_instr} !== {1'b1, pc_exp, word_of(pc_exp)}) begin
            n_fail++;
            $display("FAIL rd_newdata: got dv=%b pc=%h instr=%h, want 1 %h %h",
                     dataF.valid, dataF.pc, dataF.raw_instr, pc_exp, word_of(pc_exp));
        end
        pc_exp = pc_exp + 64'd4;
    endtask

    task automatic test_redirect_same_cycle();
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL rs_req: got v=%b addr=%h, want 1 %h", ireq.valid, ireq.addr, pc_exp);
        end
        // Completion happens on the next edge; redirect collides with it.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        d_ready        = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        n_tests++;
        if ({ireq.valid, dataF.valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rs_flush: got iv=%b dv=%b pc=%h, want 0 0",
                     ireq.valid, dataF.valid, dataF.pc);
        end
        pc_exp = 64'h8000_2000;
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL rs_newreq: got v=%b addr=%h, want 1 %h", ireq.valid, ireq.addr, pc_exp);
        end
        cyc();
        n_tests++;
        if ({dataF.valid, dataF.pc, dataF.raw_instr} !== {1'b1, pc_exp, word_of(pc_exp)}) begin
            n_fail++;
            $display("FAIL rs_newdata: got dv=%b pc=%h instr=%h, want 1 %h %h",
                     dataF.valid, dataF.pc, dataF.raw_instr, pc_exp, word_of(pc_exp));
        end
    endtask

    task automatic test_redirect_idle();
        // Slot full and decode stalled: the flush must still clear it.
        d_ready        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        cyc();
        redirect_valid = 1'b0;
        n_tests++;
        if ({ireq.valid, dataF.valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL ri_flush: got iv=%b dv=%b, want 0 0", ireq.valid, dataF.valid);
        end
        d_ready = 1'b1;
        pc_exp  = 64'h8000_3000;
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL ri_req: got v=%b addr=%h, want 1 %h", ireq.valid, ireq.addr, pc_exp);
        end
        cyc();
        n_tests++;
        if ({dataF.valid, dataF.pc} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL ri_data: got dv=%b pc=%h, want 1 %h", dataF.valid, dataF.pc, pc_exp);
        end
    endtask

    task automatic test_wrap_and_reset_mid();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        pc_exp         = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL wrap_req: got v=%b addr=%h, want 1 %h", ireq.valid, ireq.addr, pc_exp);
        end
        addr_lat = 5;
        cyc();
        n_tests++;
        if ({dataF.valid, dataF.pc, dataF.raw_instr} !== {1'b1, pc_exp, word_of(pc_exp)}) begin
            n_fail++;
            $display("FAIL wrap_data: got dv=%b pc=%h instr=%h, want 1 %h %h",
                     dataF.valid, dataF.pc, dataF.raw_instr, pc_exp, word_of(pc_exp));
        end
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr} !== {1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL wrap_next: got v=%b addr=%h, want 1 0", ireq.valid, ireq.addr);
        end
        // Still in ADDR (address phase held off); reset abandons the request.
        reset = 1'b1;
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr, dataF.valid} !== {1'b0, 64'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b addr=%h dv=%b, want 0 0 0",
                     ireq.valid, ireq.addr, dataF.valid);
        end
        reset    = 1'b0;
        addr_lat = 0;
        pc_exp   = 64'h8000_0000;
        cyc();
        n_tests++;
        if ({ireq.valid, ireq.addr} !== {1'b1, pc_exp}) begin
            n_fail++;
            $display("FAIL rst_mid_req: got v=%b addr=%h, want 1 %h", ireq.valid, ireq.addr, pc_exp);
        end
        cyc();
        n_tests++;
        if ({dataF.valid, dataF.pc, dataF.raw_instr} !== {1'b1, pc_exp, word_of(pc_exp)}) begin
            n_fail++;
            $display("FAIL rst_mid_data: got dv=%b pc=%h instr=%h, want 1 %h %h",
                     dataF.valid, dataF.pc, dataF.raw_instr, pc_exp, word_of(pc_exp));
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        d_ready        = 1'b1;
        pc_exp         = '0;
        test_reset();
        test_stream();
        test_data_delay();
        test_backpressure();
        test_redirect_data();
        test_redirect_same_cycle();
        test_redirect_idle();
        test_wrap_and_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the RV64 pipeline, directly upstream of decode. It holds the PC and issues single-outstanding requests on the instruction bus. Each returned 32-bit word is registered with its PC into a one-entry output slot that decode consumes through a valid/ready handshake. Redirects from later stages (branches, jumps) flush the slot and squash any request already in flight.

## Interface
Parameters:
- PCINIT, 64'h0000_0000_8000_0000, PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ireq  output  ibus_req_t  fields valid, addr (u64)
- iresp  input  ibus_resp_t  fields addr_ok, data_ok, data (u32)
- redirect_valid  input  1  later stage requests PC change this cycle
- redirect_pc  input  u64  new PC, 4-byte aligned
- d_ready  input  1  decode accepts the output slot this cycle
- dataF  output  fetch_data_t  fields valid, pc (u64), raw_instr (u32)

## Operation
- State machine fetch_state_t with states IDLE, ADDR, DATA. Registers: pc, req_pc, stale, and output slot {valid, pc, raw_instr}.
- Slot consumption: the slot is consumed on any cycle where dataF.valid && d_ready. When consumed and not refilled that cycle, dataF.valid clears.
- IDLE: with no redirect, moves to ADDR when (!dataF.valid || d_ready), latching req_pc <= pc. Otherwise stays in IDLE.
- ADDR: ireq.valid=1 and ireq.addr=req_pc, both held stable until addr_ok.
  - addr_ok && data_ok in the same cycle: completes directly and goes to IDLE.
  - addr_ok alone: goes to DATA.
- DATA: ireq.valid=0. Waits for data_ok, then goes to IDLE.
- Completion (data_ok while in ADDR or DATA):
  - stale=0 and no redirect that cycle: slot <= {1, req_pc, iresp.data}; pc <= req_pc+4.
  - Otherwise the data is dropped and the slot is not written.
  - stale clears on completion in either case.
- Redirect (redirect_valid=1), in any state:
  - pc <= redirect_pc and dataF.valid <= 0. The flush wins over a same-cycle d_ready and over a same-cycle completion.
  - If in ADDR or DATA and not completing this cycle: stale <= 1. The request runs to completion and its data is discarded.
  - Redirect in IDLE: stays in IDLE. It fetches redirect_pc starting from the next cycle.
- Redirect while stale=1: updates pc only. The last redirect wins.
- PC arithmetic is 64-bit and wraps modulo 2^64. ireq.addr carries the PC unmodified.

## Timing
- During reset and on the cycle after: state=IDLE, pc=PCINIT, stale=0, dataF.valid=0, dataF.pc=0, dataF.raw_instr=0, ireq.valid=0, ireq.addr=0.
- Reset asserted mid-request abandons the bus transaction without waiting for data_ok. The bus is reset together with the core.
- ireq is a registered function of state, with no combinational path from iresp to ireq. dataF is a registered output.
- Best case: IDLE at cycle n, ADDR with addr_ok and data_ok at n+1, dataF.valid at n+2. Steady-state throughput is one instruction per 2 cycles.
- Each extra cycle of addr_ok or data_ok delay adds one cycle.
- Backpressure: while dataF.valid && !d_ready, no new request is started and dataF holds stable.

## Structure
- Package pipes:
  - fetch_data_t {valid, pc, raw_instr}, consumed by decode, which feeds raw_instr to the immediate generator.
  - fetch_state_t enum.
- Package common: ibus_req_t, ibus_resp_t, u32, u64, and PCINIT default constant.
- Single module. No sub-module needed; the PC-next mux stays inline.

## Test plan
- Reset release, bus answers addr_ok and data_ok in the same cycle, d_ready=1 -> ireq.addr sequence 8000_0000, 8000_0004, 8000_0008. dataF.valid every other cycle with the matching pc and raw_instr.
- data_ok delayed 3 cycles after addr_ok -> ireq.valid low during the wait. Exactly one dataF per request, pc advances by 4 each time.
- d_ready=0 for 5 cycles with slot full -> no ireq.valid during the stall. dataF stable.
- Redirect to 8000_1000 while in DATA, then data_ok with word 0xDEADBEEF -> dataF.valid stays 0, word dropped. Next ireq.addr=8000_1000.
- Redirect in the same cycle as data_ok and d_ready=1 -> slot flushed, no write. pc=redirect_pc.
- Reset asserted while in ADDR -> next cycle ireq.valid=0, pc=PCINIT, dataF.valid=0.
